microcode_sequencer: RTL and testbench
======================================

// Module: microcode_sequencer
// PURPOSE
//  Reader end of the microcode ROM port: issues micro_pc every cycle and consumes micro_data one clock later.
//  Decodes the sequencing field of the current micro-word: next, jump, conditional branch, call/return, dispatch, wait, halt.
//  Holds a small return stack.
//  Sits between memory_registers (ROM) and the ao68000 control path.
// PARAMETERS
//  RESET_PC      9'd0    address fetched after reset release
//  INTERRUPT_PC  9'd480  dispatch override target when interrupt_pending=1
//  EXCEPTION_PC  9'd490  target on return-stack underflow or illegal seq op
//  STACK_DEPTH   4       return-stack entries (1..8)
// PORTS
//  clock              in   1   rising-edge clock
//  reset_n            in   1   async active-low reset
//  micro_pc           out  9   ROM address; combinational from state and micro_data; ROM registers it, data valid next cycle
//  micro_data         in   88  ROM word for the previous micro_pc
//  condition_true     in   1   datapath condition for the current micro-word
//  decoder_target     in   9   instruction-decoder dispatch address
//  interrupt_pending  in   1   sampled only on DISPATCH
//  stall              in   1   bus/datapath wait; freezes sequencing
//  micro_valid        out  1   micro_data holds a real word (reg, reset 0)
//  current_pc         out  9   address of the word now in micro_data (reg, reset RESET_PC)
//  halted             out  1   HALT executed (sticky, reset 0)
//  stack_error        out  1   overflow/underflow/illegal op seen (sticky, reset 0)
// BEHAVIOUR
//  Fields: seq_op = micro_data[87:84], seq_target = micro_data[83:75].
//  Reset asserted: micro_pc=RESET_PC, sp=0, all registered outputs at reset values.
//  First cycle after release: micro_valid=0, micro_pc=RESET_PC, and seq_op is ignored. micro_valid=1 from the next cycle on.
//  States:
//   - BOOT -> RUN after 1 cycle.
//   - RUN -> HALT on seq_op HALT.
//   - HALT: micro_pc=current_pc, exited only by reset.
//  stall=1, or micro_valid=0 outside BOOT: micro_pc=current_pc, stack/flags frozen.
//  In RUN with stall=0, next is the address issued as micro_pc; current_pc<=next on the edge.
//  seq_op decode:
//   0 NEXT:   next = current_pc+1, wraps 511->0.
//   1 JUMP:   next = seq_target.
//   2 BR_T:   next = condition_true ? seq_target : pc+1.
//   3 BR_F:   next = condition_true ? pc+1 : seq_target.
//   4 CALL:   push pc+1, next = seq_target.
//       Stack full: no push, target still taken, stack_error<=1.
//   5 RET:    next = popped value.
//       Stack empty: next = EXCEPTION_PC, stack_error<=1.
//   6 DISPATCH: next = interrupt_pending ? INTERRUPT_PC : decoder_target.
//   7 WAIT:   next = condition_true ? pc+1 : current_pc.
//   8 HALT:   next = current_pc, halted<=1.
//   9..15:    next = EXCEPTION_PC, stack_error<=1.
//  Arithmetic: 9-bit modulo; sp is clog2(STACK_DEPTH)+1 bits.
//  Simultaneous stall with any op: stall wins, op is re-evaluated when stall drops (ROM re-reads the same word).
//  Reset mid-operation: stack cleared, next fetch is RESET_PC; no partial push/pop survives.
// STRUCTURE
//  Shared header ao68000_micro_defs.vh:
//   - SEQ_* op encodings
//   - field bit positions (SEQ_OP_HI/LO, SEQ_TGT_HI/LO)
//   - state encodings
//  Sub-module microcode_return_stack:
//   - LIFO: push/pop/full/empty, DEPTH param
//   - async reset; push and pop never both asserted
// TESTING
//  1. Reset release, ROM words all NEXT -> micro_pc 0,1,2,3...; micro_valid 0 then 1.
//     NEXT at pc 511 -> micro_pc 0.
//  2. Branch ops at pc 10, seq_target=9'd100:
//     - BR_T with condition_true=1 -> micro_pc 100; with condition_true=0 -> micro_pc 11.
//     - BR_F gives the opposite results.
//  3. CALL 200 at pc 20, RET at pc 200 -> micro_pc 200 then 21.
//     5 nested CALLs with DEPTH=4 -> stack_error=1 on the 5th, target still taken.
//  4. RET on empty stack -> micro_pc 490, stack_error=1.
//     seq_op 4'hF -> micro_pc 490.
//  5. DISPATCH with decoder_target=9'h1A0:
//     - interrupt_pending=0 -> micro_pc 1A0; interrupt_pending=1 -> micro_pc 480.
//     - stall held 3 cycles -> micro_pc = current_pc throughout, then 1A0.
//  6. WAIT with condition_true=0 for 4 cycles, then 1 -> micro_pc repeats, then pc+1.
//     HALT -> halted=1, micro_pc frozen until reset_n pulse returns to RESET_PC.

Source files
------------

// File: rtl/microcode_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: micro-word field
// positions, sequencing op encodings and sequencer state encodings.
package microcode_sequencer_pkg;

    localparam int PC_W       = 9;
    localparam int WORD_W     = 88;

    localparam int SEQ_OP_HI  = 87;
    localparam int SEQ_OP_LO  = 84;
    localparam int SEQ_TGT_HI = 83;
    localparam int SEQ_TGT_LO = 75;

    typedef enum logic [3:0] {
        SEQ_NEXT     = 4'd0,
        SEQ_JUMP     = 4'd1,
        SEQ_BR_T     = 4'd2,
        SEQ_BR_F     = 4'd3,
        SEQ_CALL     = 4'd4,
        SEQ_RET      = 4'd5,
        SEQ_DISPATCH = 4'd6,
        SEQ_WAIT     = 4'd7,
        SEQ_HALT     = 4'd8
    } seq_op_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

    // Micro-address increment; wraps 511 -> 0 through 9-bit truncation.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/microcode_sequencer_if.sv
// ROM port and control-path signals between the microcode sequencer
// (master) and the ROM / datapath side (slave).
interface microcode_sequencer_if;
    import microcode_sequencer_pkg::*;

    logic [PC_W-1:0]   micro_pc;
    logic [WORD_W-1:0] micro_data;
    logic              condition_true;
    logic [PC_W-1:0]   decoder_target;
    logic              interrupt_pending;
    logic              stall;
    logic              micro_valid;
    logic [PC_W-1:0]   current_pc;
    logic              halted;
    logic              stack_error;

    modport master (
        output micro_pc, micro_valid, current_pc, halted, stack_error,
        input  micro_data, condition_true, decoder_target, interrupt_pending, stall
    );

    modport slave (
        input  micro_pc, micro_valid, current_pc, halted, stack_error,
        output micro_data, condition_true, decoder_target, interrupt_pending, stall
    );

endinterface

// File: rtl/microcode_return_stack.sv
// Small LIFO holding micro-subroutine return addresses. Push while full and
// pop while empty are ignored here; the sequencer flags them as errors.
module microcode_return_stack
    import microcode_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PC_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty
);

    localparam int SP_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]  sp;
    logic [WIDTH-1:0] entries [DEPTH];

    assign full     = (sp == SP_W'(DEPTH));
    assign empty    = (sp == '0);
    assign top_data = entries[IDX_W'(sp - 1'b1)];

    // Stack pointer: counts occupied entries, cleared by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

    // Entry storage: written at the slot just above the current top.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            entries[IDX_W'(sp)] <= push_data;
        end
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: drives the ROM address each cycle, decodes the
// sequencing field of the word returned one cycle later and tracks the
// return stack, halt and error status for the control path.
module microcode_sequencer
    import microcode_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = 9'd0,
    parameter logic [PC_W-1:0] INTERRUPT_PC = 9'd480,
    parameter logic [PC_W-1:0] EXCEPTION_PC = 9'd490,
    parameter int              STACK_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    microcode_sequencer_if.master bus
);

    seq_state_t      state;
    logic [PC_W-1:0] current_pc;
    logic            micro_valid;
    logic            halted;
    logic            stack_error;

    logic [3:0]      seq_op;
    logic [PC_W-1:0] seq_target;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] ret_addr;
    logic            advance;
    logic            do_push;
    logic            do_pop;
    logic            set_error;
    logic            set_halt;
    logic            stk_full;
    logic            stk_empty;
    logic            unused_word_bits;

    assign seq_op           = bus.micro_data[SEQ_OP_HI:SEQ_OP_LO];
    assign seq_target       = bus.micro_data[SEQ_TGT_HI:SEQ_TGT_LO];
    assign unused_word_bits = ^bus.micro_data[SEQ_TGT_LO-1:0];
    assign pc_plus1         = pc_inc(current_pc);

    // Only a valid, unstalled word in RUN may move the sequencer.
    assign advance = (state == ST_RUN) && micro_valid && !bus.stall;

    // Next-address selection plus the stack and flag effects of the current word.
    always_comb begin
        next_pc   = current_pc;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        set_error = 1'b0;
        set_halt  = 1'b0;
        if (state == ST_BOOT) begin
            next_pc = RESET_PC;
        end else if (advance) begin
            case (seq_op)
                SEQ_NEXT:     next_pc = pc_plus1;
                SEQ_JUMP:     next_pc = seq_target;
                SEQ_BR_T:     next_pc = bus.condition_true ? seq_target : pc_plus1;
                SEQ_BR_F:     next_pc = bus.condition_true ? pc_plus1 : seq_target;
                SEQ_CALL: begin
                    next_pc   = seq_target;
                    do_push   = !stk_full;
                    set_error = stk_full;
                end
                SEQ_RET: begin
                    if (stk_empty) begin
                        next_pc   = EXCEPTION_PC;
                        set_error = 1'b1;
                    end else begin
                        next_pc = ret_addr;
                        do_pop  = 1'b1;
                    end
                end
                SEQ_DISPATCH: next_pc = bus.interrupt_pending ? INTERRUPT_PC : bus.decoder_target;
                SEQ_WAIT:     next_pc = bus.condition_true ? pc_plus1 : current_pc;
                SEQ_HALT: begin
                    next_pc  = current_pc;
                    set_halt = 1'b1;
                end
                default: begin
                    next_pc   = EXCEPTION_PC;
                    set_error = 1'b1;
                end
            endcase
        end
    end

    microcode_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_return_stack (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (pc_plus1),
        .top_data  (ret_addr),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Sequencer FSM with registered status outputs; HALT is left only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_BOOT;
            current_pc  <= RESET_PC;
            micro_valid <= 1'b0;
            halted      <= 1'b0;
            stack_error <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state       <= ST_RUN;
                    current_pc  <= RESET_PC;
                    micro_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (advance) begin
                        current_pc <= next_pc;
                        if (set_halt) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                        if (set_error) begin
                            stack_error <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

    assign bus.micro_pc    = next_pc;
    assign bus.current_pc  = current_pc;
    assign bus.micro_valid = micro_valid;
    assign bus.halted      = halted;
    assign bus.stack_error = stack_error;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Testbench for microcode_sequencer: a registered ROM array feeds the DUT,
// directed scenarios check fixed address sequences and a randomized run is
// compared against a queue-based behavioural model.
module tb_microcode_sequencer;
    import microcode_sequencer_pkg::*;

    localparam logic [8:0] RESET_PC = 9'd0;
    localparam logic [8:0] INT_PC   = 9'd480;
    localparam logic [8:0] EXC_PC   = 9'd490;
    localparam int         DEPTH    = 4;

    logic clock = 1'b0;
    logic reset_n;
    microcode_sequencer_if bus();

    logic [87:0] rom [0:511];
    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [8:0] m_pc;
    logic       m_boot, m_valid, m_halt, m_err;
    logic [8:0] m_stack [$];

    microcode_sequencer #(
        .RESET_PC     (RESET_PC),
        .INTERRUPT_PC (INT_PC),
        .EXCEPTION_PC (EXC_PC),
        .STACK_DEPTH  (DEPTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // ROM model: registers the address, data valid the next cycle.
    always @(posedge clock) bus.micro_data <= rom[bus.micro_pc];

    function automatic logic [87:0] mw(input logic [3:0] op, input logic [8:0] tgt);
        return {op, tgt, 43'd0, 32'($urandom())};
    endfunction

    function automatic logic [3:0] rand_op();
        int r;
        r = $urandom_range(0, 99);
        if (r < 35) return SEQ_NEXT;
        if (r < 45) return SEQ_JUMP;
        if (r < 55) return SEQ_BR_T;
        if (r < 65) return SEQ_BR_F;
        if (r < 74) return SEQ_CALL;
        if (r < 83) return SEQ_RET;
        if (r < 88) return SEQ_DISPATCH;
        if (r < 94) return SEQ_WAIT;
        if (r < 95) return SEQ_HALT;
        return 4'($urandom_range(9, 15));
    endfunction

    // Expected ROM address for the current cycle.
    function automatic logic [8:0] model_pc();
        logic [3:0] op;
        logic [8:0] tgt;
        if (m_boot) return RESET_PC;
        if (m_halt || bus.stall) return m_pc;
        op  = rom[m_pc][87:84];
        tgt = rom[m_pc][83:75];
        case (op)
            4'd0: return m_pc + 9'd1;
            4'd1: return tgt;
            4'd2: return bus.condition_true ? tgt : m_pc + 9'd1;
            4'd3: return bus.condition_true ? m_pc + 9'd1 : tgt;
            4'd4: return tgt;
            4'd5: return (m_stack.size() > 0) ? m_stack[$] : EXC_PC;
            4'd6: return bus.interrupt_pending ? INT_PC : bus.decoder_target;
            4'd7: return bus.condition_true ? m_pc + 9'd1 : m_pc;
            4'd8: return m_pc;
            default: return EXC_PC;
        endcase
    endfunction

    // Model update at a rising edge, using the inputs present before it.
    task automatic model_clock();
        logic [8:0] nx;
        logic [3:0] op;
        if (!reset_n) return;
        if (m_boot) begin
            m_boot = 1'b0; m_valid = 1'b1; m_pc = RESET_PC;
            return;
        end
        if (m_halt || bus.stall) return;
        nx = model_pc();
        op = rom[m_pc][87:84];
        if (op == 4'd4) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 9'd1);
            else m_err = 1'b1;
        end else if (op == 4'd5) begin
            if (m_stack.size() > 0) void'(m_stack.pop_back());
            else m_err = 1'b1;
        end else if (op == 4'd8) begin
            m_halt = 1'b1;
        end else if (op >= 4'd9) begin
            m_err = 1'b1;
        end
        m_pc = nx;
    endtask

    task automatic tick();
        @(posedge clock);
        model_clock();
        #1;
    endtask

    // Called just after a rising edge: reset asserted at once, released two edges later.
    task automatic apply_reset();
        reset_n   = 1'b0;
        bus.stall = 1'b0;
        m_boot = 1'b1; m_valid = 1'b0; m_pc = RESET_PC; m_halt = 1'b0; m_err = 1'b0;
        m_stack.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic fill_rom(input logic [3:0] op);
        for (int a = 0; a < 512; a++) rom[a] = mw(op, 9'd0);
    endtask

    task automatic test_reset();
        fill_rom(SEQ_NEXT);
        @(negedge clock);
        total++; if (bus.micro_pc !== RESET_PC) begin bad++; $display("FAIL reset_micro_pc got=%0d exp=%0d", bus.micro_pc, RESET_PC); end
        total++; if (bus.micro_valid !== 1'b0) begin bad++; $display("FAIL reset_micro_valid got=%b exp=0", bus.micro_valid); end
        total++; if (bus.current_pc !== RESET_PC) begin bad++; $display("FAIL reset_current_pc got=%0d exp=%0d", bus.current_pc, RESET_PC); end
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
        total++; if (bus.stack_error !== 1'b0) begin bad++; $display("FAIL reset_stack_error got=%b exp=0", bus.stack_error); end
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            total++; if (bus.micro_pc !== 9'(k)) begin bad++; $display("FAIL next_seq[%0d] got=%0d exp=%0d", k, bus.micro_pc, k); end
            total++; if (bus.micro_valid !== (k != 0)) begin bad++; $display("FAIL next_valid[%0d] got=%b exp=%b", k, bus.micro_valid, (k != 0)); end
            if (k > 0) begin
                total++; if (bus.current_pc !== 9'(k - 1)) begin bad++; $display("FAIL next_cur[%0d] got=%0d exp=%0d", k, bus.current_pc, k - 1); end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        int seq [6] = '{0, 510, 511, 0, 510, 511};
        fill_rom(SEQ_NEXT);
        rom[0] = mw(SEQ_JUMP, 9'd510);
        apply_reset();
        foreach (seq[k]) begin
            @(negedge clock);
            total++; if (bus.micro_pc !== 9'(seq[k])) begin bad++; $display("FAIL wrap[%0d] got=%0d exp=%0d", k, bus.micro_pc, seq[k]); end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [3:0] ops  [4] = '{SEQ_BR_T, SEQ_BR_T, SEQ_BR_F, SEQ_BR_F};
        logic       conds[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int         exps [4] = '{100, 11, 11, 100};
        for (int i = 0; i < 4; i++) begin
            fill_rom(SEQ_NEXT);
            rom[0]  = mw(SEQ_JUMP, 9'd10);
            rom[10] = mw(ops[i], 9'd100);
            apply_reset();
            bus.condition_true = 1'($urandom_range(0, 1));
            tick();
            tick();
            bus.condition_true = conds[i];
            @(negedge clock);
            total++; if (bus.micro_pc !== 9'(exps[i])) begin bad++; $display("FAIL branch[%0d] got=%0d exp=%0d", i, bus.micro_pc, exps[i]); end
            tick();
            @(negedge clock);
            total++; if (bus.current_pc !== 9'(exps[i])) begin bad++; $display("FAIL branch_cur[%0d] got=%0d exp=%0d", i, bus.current_pc, exps[i]); end
            tick();
        end
    endtask

    task automatic test_call_ret();
        int seq1 [5]  = '{0, 20, 200, 21, 22};
        int seq2 [11] = '{0, 50, 60, 70, 80, 90, 71, 61, 51, 1, 490};
        fill_rom(SEQ_NEXT);
        rom[0]   = mw(SEQ_JUMP, 9'd20);
        rom[20]  = mw(SEQ_CALL, 9'd200);
        rom[200] = mw(SEQ_RET, 9'd0);
        apply_reset();
        foreach (seq1[k]) begin
            @(negedge clock);
            total++; if (bus.micro_pc !== 9'(seq1[k])) begin bad++; $display("FAIL call_ret[%0d] got=%0d exp=%0d", k, bus.micro_pc, seq1[k]); end
            tick();
        end
        total++; if (bus.stack_error !== 1'b0) begin bad++; $display("FAIL call_ret_err got=%b exp=0", bus.stack_error); end
        fill_rom(SEQ_NEXT);
        rom[0]  = mw(SEQ_CALL, 9'd50);
        rom[50] = mw(SEQ_CALL, 9'd60);
        rom[60] = mw(SEQ_CALL, 9'd70);
        rom[70] = mw(SEQ_CALL, 9'd80);
        rom[80] = mw(SEQ_CALL, 9'd90);
        rom[90] = mw(SEQ_RET, 9'd0);
        rom[71] = mw(SEQ_RET, 9'd0);
        rom[61] = mw(SEQ_RET, 9'd0);
        rom[51] = mw(SEQ_RET, 9'd0);
        rom[1]  = mw(SEQ_RET, 9'd0);
        apply_reset();
        foreach (seq2[k]) begin
            @(negedge clock);
            total++; if (bus.micro_pc !== 9'(seq2[k])) begin bad++; $display("FAIL nested[%0d] got=%0d exp=%0d", k, bus.micro_pc, seq2[k]); end
            total++; if (bus.stack_error !== (k >= 6)) begin bad++; $display("FAIL nested_err[%0d] got=%b exp=%b", k, bus.stack_error, (k >= 6)); end
            tick();
        end
    endtask

    task automatic test_exceptions();
        logic [3:0] ops [2] = '{SEQ_RET, 4'hF};
        for (int i = 0; i < 2; i++) begin
            fill_rom(SEQ_NEXT);
            rom[0] = mw(ops[i], 9'($urandom_range(0, 511)));
            apply_reset();
            tick();
            @(negedge clock);
            total++; if (bus.micro_pc !== EXC_PC) begin bad++; $display("FAIL exc_pc[%0d] got=%0d exp=%0d", i, bus.micro_pc, EXC_PC); end
            total++; if (bus.stack_error !== 1'b0) begin bad++; $display("FAIL exc_err_before[%0d] got=%b exp=0", i, bus.stack_error); end
            tick();
            @(negedge clock);
            total++; if (bus.stack_error !== 1'b1) begin bad++; $display("FAIL exc_err[%0d] got=%b exp=1", i, bus.stack_error); end
            total++; if (bus.micro_pc !== EXC_PC + 9'd1) begin bad++; $display("FAIL exc_next[%0d] got=%0d exp=%0d", i, bus.micro_pc, EXC_PC + 9'd1); end
            tick();
        end
    endtask

    task automatic test_dispatch();
        bus.decoder_target = 9'h1A0;
        for (int i = 0; i < 2; i++) begin
            fill_rom(SEQ_NEXT);
            rom[0] = mw(SEQ_DISPATCH, 9'($urandom_range(0, 511)));
            bus.interrupt_pending = (i == 1);
            apply_reset();
            tick();
            @(negedge clock);
            total++; if (bus.micro_pc !== ((i == 1) ? INT_PC : 9'h1A0)) begin bad++; $display("FAIL dispatch[%0d] got=%0d exp=%0d", i, bus.micro_pc, (i == 1) ? INT_PC : 9'h1A0); end
            tick();
        end
        bus.interrupt_pending = 1'b0;
        apply_reset();
        tick();
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            total++; if (bus.micro_pc !== 9'd0) begin bad++; $display("FAIL stall_pc[%0d] got=%0d exp=0", k, bus.micro_pc); end
            total++; if (bus.current_pc !== 9'd0) begin bad++; $display("FAIL stall_cur[%0d] got=%0d exp=0", k, bus.current_pc); end
            tick();
        end
        bus.stall = 1'b0;
        @(negedge clock);
        total++; if (bus.micro_pc !== 9'h1A0) begin bad++; $display("FAIL stall_release got=%0d exp=%0d", bus.micro_pc, 9'h1A0); end
        tick();
    endtask

    task automatic test_wait_halt();
        fill_rom(SEQ_NEXT);
        rom[0]  = mw(SEQ_JUMP, 9'd30);
        rom[30] = mw(SEQ_WAIT, 9'($urandom_range(0, 511)));
        rom[31] = mw(SEQ_HALT, 9'($urandom_range(0, 511)));
        apply_reset();
        tick();
        tick();
        bus.condition_true = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            total++; if (bus.micro_pc !== 9'd30) begin bad++; $display("FAIL wait[%0d] got=%0d exp=30", k, bus.micro_pc); end
            tick();
        end
        bus.condition_true = 1'b1;
        @(negedge clock);
        total++; if (bus.micro_pc !== 9'd31) begin bad++; $display("FAIL wait_done got=%0d exp=31", bus.micro_pc); end
        tick();
        @(negedge clock);
        total++; if (bus.micro_pc !== 9'd31) begin bad++; $display("FAIL halt_pc got=%0d exp=31", bus.micro_pc); end
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL halt_before got=%b exp=0", bus.halted); end
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.condition_true = 1'($urandom_range(0, 1));
            bus.stall          = 1'($urandom_range(0, 1));
            @(negedge clock);
            total++; if (bus.micro_pc !== 9'd31) begin bad++; $display("FAIL halt_frozen[%0d] got=%0d exp=31", k, bus.micro_pc); end
            total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL halted[%0d] got=%b exp=1", k, bus.halted); end
            tick();
        end
        apply_reset();
        @(negedge clock);
        total++; if (bus.micro_pc !== RESET_PC) begin bad++; $display("FAIL halt_reset_pc got=%0d exp=%0d", bus.micro_pc, RESET_PC); end
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL halt_reset_flag got=%b exp=0", bus.halted); end
        tick();
        @(negedge clock);
        total++; if (bus.micro_pc !== 9'd30) begin bad++; $display("FAIL halt_restart got=%0d exp=30", bus.micro_pc); end
        tick();
    endtask

    task automatic test_random();
        logic [8:0] exp_pc;
        for (int round = 0; round < 4; round++) begin
            for (int a = 0; a < 512; a++) rom[a] = mw(rand_op(), 9'($urandom_range(0, 511)));
            apply_reset();
            for (int c = 0; c < 150; c++) begin
                if ((c == 70 && round % 2 == 1) || (m_halt && $urandom_range(0, 7) == 0)) apply_reset();
                bus.condition_true    = 1'($urandom_range(0, 1));
                bus.stall             = m_boot ? 1'b0 : ($urandom_range(0, 4) == 0);
                bus.interrupt_pending = ($urandom_range(0, 3) == 0);
                bus.decoder_target    = 9'($urandom_range(0, 511));
                @(negedge clock);
                exp_pc = model_pc();
                total++; if (bus.micro_pc !== exp_pc) begin bad++; $display("FAIL rand_pc[%0d.%0d] got=%0d exp=%0d", round, c, bus.micro_pc, exp_pc); end
                total++; if (bus.current_pc !== m_pc) begin bad++; $display("FAIL rand_cur[%0d.%0d] got=%0d exp=%0d", round, c, bus.current_pc, m_pc); end
                total++; if (bus.micro_valid !== m_valid) begin bad++; $display("FAIL rand_valid[%0d.%0d] got=%b exp=%b", round, c, bus.micro_valid, m_valid); end
                total++; if (bus.halted !== m_halt) begin bad++; $display("FAIL rand_halted[%0d.%0d] got=%b exp=%b", round, c, bus.halted, m_halt); end
                total++; if (bus.stack_error !== m_err) begin bad++; $display("FAIL rand_err[%0d.%0d] got=%b exp=%b", round, c, bus.stack_error, m_err); end
                tick();
            end
        end
    endtask

    initial begin
        reset_n               = 1'b1;
        bus.stall             = 1'b0;
        bus.condition_true    = 1'b0;
        bus.interrupt_pending = 1'b0;
        bus.decoder_target    = 9'd0;
        m_boot = 1'b1; m_valid = 1'b0; m_pc = RESET_PC; m_halt = 1'b0; m_err = 1'b0;
        #2 reset_n = 1'b0;
        test_reset();
        test_wrap();
        test_branch();
        test_call_ret();
        test_exceptions();
        test_dispatch();
        test_wait_halt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
